// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix calculator datapaths.
// Matrices are row-major packed, element (r,c) at elem_off(r,c).
package matrix_pkg;

    localparam int unsigned DIM_MAX  = 5;
    localparam int unsigned ELEM_W   = 8;
    localparam int unsigned SCALAR_W = 4;
    localparam int unsigned DIM_W    = 3;
    localparam int unsigned PROD_W   = ELEM_W + SCALAR_W;
    localparam int unsigned MAT_W    = DIM_MAX * DIM_MAX * ELEM_W;
    localparam int unsigned OFF_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RUN,
        DONE
    } seq_state_e;

    // Operand bundle captured when an operation is accepted
    typedef struct packed {
        logic [DIM_W-1:0]    m;
        logic [DIM_W-1:0]    n;
        logic [SCALAR_W-1:0] scalar;
        logic [MAT_W-1:0]    mat;
    } scalar_op_t;

    function automatic logic [OFF_W-1:0] elem_off(input logic [DIM_W-1:0] r,
                                                  input logic [DIM_W-1:0] c);
        return OFF_W'((32'(r) * DIM_MAX + 32'(c)) * ELEM_W);
    endfunction

endpackage

// File: rtl/mat_index_counter.sv
// Row-major element walker over an m x n region; last_c flags (m-1, n-1).
module mat_index_counter
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] m,
    input  logic [DIM_W-1:0] n,
    output logic [DIM_W-1:0] row,
    output logic [DIM_W-1:0] col,
    output logic             last_c
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == n - DIM_W'(1)) begin
                col <= '0;
                row <= row + DIM_W'(1);
            end else begin
                col <= col + DIM_W'(1);
            end
        end
    end

    assign last_c = (row == m - DIM_W'(1)) && (col == n - DIM_W'(1));

endmodule

// File: rtl/scalar_mul_sequencer.sv
// Element-serial scalar multiply: one shared 8x4 multiplier stepped across
// an m x n matrix, one element per clock, with start/busy/done handshake.
module scalar_mul_sequencer
    import matrix_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DIM_W-1:0]    m,
    input  logic [DIM_W-1:0]    n,
    input  logic [SCALAR_W-1:0] scalar_value,
    input  logic [MAT_W-1:0]    mat_in,
    output logic [MAT_W-1:0]    mat_out,
    output logic                busy,
    output logic                done,
    output logic                error
);

    seq_state_e       state, state_next;
    scalar_op_t       op_q;
    logic             busy_next, done_next, error_next;
    logic             latch_c, clear_idx_c, write_c;
    logic             dims_ok_c, last_c;
    logic [DIM_W-1:0] row, col;
    logic [ELEM_W-1:0] elem_c, prod_lo_c;

    mat_index_counter u_idx (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_idx_c),
        .advance (write_c),
        .m       (op_q.m),
        .n       (op_q.n),
        .row     (row),
        .col     (col),
        .last_c  (last_c)
    );

    assign dims_ok_c = (op_q.m != '0) && (op_q.m <= DIM_W'(DIM_MAX)) &&
                       (op_q.n != '0) && (op_q.n <= DIM_W'(DIM_MAX));

    // Shared multiplier; only the low byte of the 12-bit product is kept
    assign elem_c    = op_q.mat[elem_off(row, col) +: ELEM_W];
    assign prod_lo_c = ELEM_W'(PROD_W'(elem_c) * PROD_W'(op_q.scalar));

    always_comb begin
        state_next  = state;
        busy_next   = busy;
        done_next   = 1'b0;
        error_next  = error;
        latch_c     = 1'b0;
        clear_idx_c = 1'b0;
        write_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    latch_c    = 1'b1;
                    busy_next  = 1'b1;
                    error_next = 1'b0;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (!dims_ok_c) begin
                    done_next  = 1'b1;
                    error_next = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    clear_idx_c = 1'b1;
                    state_next  = RUN;
                end
            end
            RUN: begin
                write_c = 1'b1;
                if (last_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            mat_out <= '0;
            op_q    <= '0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
            done  <= done_next;
            error <= error_next;
            if (latch_c) begin
                op_q    <= '{m: m, n: n, scalar: scalar_value, mat: mat_in};
                mat_out <= '0;
            end else if (write_c) begin
                mat_out[elem_off(row, col) +: ELEM_W] <= prod_lo_c;
            end
        end
    end

endmodule

// File: tb/tb_scalar_mul_sequencer.sv
// Directed and randomized checks of scalar_mul_sequencer against an
// arithmetic reference model of the element-wise scalar product.
module tb_scalar_mul_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   m, n;
    logic [3:0]   scalar_value;
    logic [199:0] mat_in, mat_out;
    logic         busy, done, error;

    int errors = 0;
    int checks = 0;

    scalar_mul_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .m            (m),
        .n            (n),
        .scalar_value (scalar_value),
        .mat_in       (mat_in),
        .mat_out      (mat_out),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [199:0] rand_mat();
        logic [199:0] r;
        for (int i = 0; i < 25; i++) r[i*8 +: 8] = 8'($urandom_range(1, 255));
        return r;
    endfunction

    // Reference: each in-region element times scalar, modulo 256; zero elsewhere
    function automatic logic [199:0] model(input int mm, input int nn, input int ss,
                                           input logic [199:0] mat);
        logic [199:0] res;
        int e;
        res = '0;
        if (mm >= 1 && mm <= 5 && nn >= 1 && nn <= 5) begin
            for (int r = 0; r < mm; r++) begin
                for (int c = 0; c < nn; c++) begin
                    e = int'(mat[(r*5+c)*8 +: 8]);
                    res[(r*5+c)*8 +: 8] = 8'((e * ss) % 256);
                end
            end
        end
        return res;
    endfunction

    task automatic run_op(input int mm, input int nn, input int ss,
                          input logic [199:0] mat, input int inject_edge, input string tag);
        logic [199:0] exp_mat;
        int exp_edge, busy_cycles, done_edge;
        bit valid;
        valid    = (mm >= 1 && mm <= 5 && nn >= 1 && nn <= 5);
        exp_mat  = model(mm, nn, ss, mat);
        exp_edge = valid ? mm * nn + 2 : 1;
        m = 3'(mm); n = 3'(nn); scalar_value = 4'(ss); mat_in = mat; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ":busy_after_start"}, 200'(busy), 200'(1));
        check({tag, ":error_cleared"}, 200'(error), 200'(0));
        // Scramble inputs to show operands were latched
        mat_in = rand_mat(); m = 3'($urandom); n = 3'($urandom);
        scalar_value = 4'($urandom);
        busy_cycles = 1;
        done_edge = -1;
        for (int k = 1; k <= 60 && done_edge < 0; k++) begin
            if (k == inject_edge) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) busy_cycles++;
            if (done) done_edge = k;
        end
        check({tag, ":done_edge"}, 200'(done_edge), 200'(exp_edge));
        check({tag, ":busy_cycles"}, 200'(busy_cycles), 200'(exp_edge));
        check({tag, ":error"}, 200'(error), 200'(!valid));
        check({tag, ":mat_out"}, mat_out, exp_mat);
        @(posedge clk); #1;
        check({tag, ":done_single"}, 200'(done), 200'(0));
        check({tag, ":idle_busy"}, 200'(busy), 200'(0));
        check({tag, ":hold"}, mat_out, exp_mat);
    endtask

    initial begin
        logic [199:0] mat, exp_c;
        reset = 1'b1; start = 1'b0; m = '0; n = '0; scalar_value = '0; mat_in = '0;
        #12;
        check("reset:mat_out", mat_out, 200'(0));
        check("reset:busy", 200'(busy), 200'(0));
        check("reset:done", 200'(done), 200'(0));
        check("reset:error", 200'(error), 200'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // 2x3, scalar 3, junk outside region
        for (int i = 0; i < 25; i++) mat[i*8 +: 8] = 8'h5A;
        mat[0*8 +: 8] = 8'd1; mat[1*8 +: 8] = 8'd2; mat[2*8 +: 8] = 8'd3;
        mat[5*8 +: 8] = 8'd3; mat[6*8 +: 8] = 8'd4; mat[7*8 +: 8] = 8'd5;
        run_op(2, 3, 3, mat, 0, "t2x3");
        exp_c = '0;
        exp_c[0*8 +: 8] = 8'd3; exp_c[1*8 +: 8] = 8'd6;  exp_c[2*8 +: 8] = 8'd9;
        exp_c[5*8 +: 8] = 8'd9; exp_c[6*8 +: 8] = 8'd12; exp_c[7*8 +: 8] = 8'd15;
        check("t2x3:const", mat_out, exp_c);

        // 5x5 all 200, scalar 15 -> 184
        for (int i = 0; i < 25; i++) mat[i*8 +: 8] = 8'd200;
        run_op(5, 5, 15, mat, 0, "t5x5");
        check("t5x5:elem0", 200'(mat_out[0 +: 8]), 200'(184));
        check("t5x5:elem24", 200'(mat_out[192 +: 8]), 200'(184));

        // Invalid dimensions
        run_op(0, 3, 7, rand_mat(), 0, "tm0");
        run_op(6, 2, 7, rand_mat(), 0, "tm6");

        // Start during RUN is ignored
        for (int i = 0; i < 25; i++) mat[i*8 +: 8] = 8'h5A;
        mat[0*8 +: 8] = 8'd1; mat[1*8 +: 8] = 8'd2; mat[2*8 +: 8] = 8'd3;
        mat[5*8 +: 8] = 8'd3; mat[6*8 +: 8] = 8'd4; mat[7*8 +: 8] = 8'd5;
        run_op(2, 3, 3, mat, 3, "tinj");
        check("tinj:const", mat_out, exp_c);

        // Asynchronous reset mid-RUN
        m = 3'd3; n = 3'd3; scalar_value = 4'd5; mat_in = rand_mat(); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst:mat_out", mat_out, 200'(0));
        check("rst:busy", 200'(busy), 200'(0));
        check("rst:done", 200'(done), 200'(0));
        check("rst:error", 200'(error), 200'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("rst:no_done", 200'(done), 200'(0));
        end
        mat = rand_mat();
        mat[0 +: 8] = 8'd7;
        run_op(1, 1, 2, mat, 0, "t1x1");
        check("t1x1:const", 200'(mat_out[0 +: 8]), 200'(14));

        // Zero scalar
        run_op(3, 3, 0, rand_mat(), 0, "tzero");

        // Randomized operations, including invalid dimensions
        for (int t = 0; t < 8; t++) begin
            run_op(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 15)), rand_mat(), 0, "trand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
